// File: rtl/exec_datapath.sv
// exec_datapath: execution datapath of the 16-bit multicycle core.
// Holds the register file, the A/B operand latches, the ALU operand muxes,
// the ALU, the ALUOut register, the carry flag and the write-back mux.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   instr_i               IR: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt, [7:0] imm8
//   pc_i, mdr_i           program counter and memory data register
//   rega_sel_i            A read address: 0 = rs, 1 = rd
//   reg_wrt_i             register file write enable
//   data_sel_i            write-back source: ALUOut / mdr / pc (link) / sext(imm8)
//   opa_sel_i, opb_sel_i  ALU operand selects
//   alu_sel_i             ALU operation
//   out_a_o, out_b_o      A and B latches
//   alu_out_o             ALUOut register
//   alu_res_o             combinational ALU result
//   carry_o               carry flag register
module exec_datapath #(
    parameter int unsigned DW       = 16,
    parameter int unsigned NREG     = 16,
    parameter int unsigned LINK_REG = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [15:0]   instr_i,
    input  logic [DW-1:0] pc_i,
    input  logic [DW-1:0] mdr_i,
    input  logic          rega_sel_i,
    input  logic          reg_wrt_i,
    input  logic [1:0]    data_sel_i,
    input  logic          opa_sel_i,
    input  logic [1:0]    opb_sel_i,
    input  logic [2:0]    alu_sel_i,
    output logic [DW-1:0] out_a_o,
    output logic [DW-1:0] out_b_o,
    output logic [DW-1:0] alu_out_o,
    output logic [DW-1:0] alu_res_o,
    output logic          carry_o
);

    logic [3:0]    rd, rs, rt;
    logic [7:0]    imm8;
    logic [DW-1:0] sext_imm;

    assign rd       = instr_i[11:8];
    assign rs       = instr_i[7:4];
    assign rt       = instr_i[3:0];
    assign imm8     = instr_i[7:0];
    assign sext_imm = {{(DW-8){imm8[7]}}, imm8};

    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] a_q, b_q, alu_out_q;
    logic          carry_q, carry_d;

    // Register file read
    logic [3:0]    ra, wa;
    logic [DW-1:0] rdata_a, rdata_b;

    assign ra      = rega_sel_i ? rd : rs;
    assign rdata_a = (ra == 4'd0) ? '0 : rf_q[ra];
    assign rdata_b = (rt == 4'd0) ? '0 : rf_q[rt];

    // Write-back
    logic [DW-1:0] wdata;

    assign wa = (data_sel_i == 2'b10) ? 4'(LINK_REG) : rd;

    always_comb begin
        wdata = alu_out_q;
        unique case (data_sel_i)
            2'b00: wdata = alu_out_q;
            2'b01: wdata = mdr_i;
            2'b10: wdata = pc_i;
            2'b11: wdata = sext_imm;
            default: wdata = alu_out_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (reg_wrt_i && (wa != 4'd0)) begin
            rf_q[wa] <= wdata;
        end
    end

    // ALU operand muxes
    logic [DW-1:0] op_x, op_y;

    assign op_x = opa_sel_i ? pc_i : a_q;

    always_comb begin
        op_y = '0;
        unique case (opb_sel_i)
            2'b00: op_y = {{(DW-1){1'b0}}, 1'b1};
            2'b01: op_y = b_q;
            2'b10: op_y = '0;
            2'b11: op_y = sext_imm;
            default: op_y = '0;
        endcase
    end

    // ALU; carry holds its value for the logical operations
    logic [DW:0]   sum;
    logic [DW-1:0] alu_res;

    assign sum = {1'b0, op_x} + {1'b0, op_y};

    always_comb begin
        alu_res = '0;
        carry_d = carry_q;
        unique case (alu_sel_i)
            3'b000: begin
                alu_res = sum[DW-1:0];
                carry_d = sum[DW];
            end
            3'b001: begin
                alu_res = op_x - op_y;
                carry_d = (op_x < op_y);
            end
            3'b010: alu_res = op_x & op_y;
            3'b011: alu_res = op_x | op_y;
            3'b100: alu_res = op_x ^ op_y;
            3'b101: alu_res = ~op_x;
            3'b110: begin
                alu_res = {op_x[DW-2:0], 1'b0};
                carry_d = op_x[DW-1];
            end
            3'b111: begin
                alu_res = {1'b0, op_x[DW-1:1]};
                carry_d = op_x[0];
            end
            default: alu_res = '0;
        endcase
    end

    // Operand latches and ALUOut capture unconditionally; the control FSM
    // sequences when their contents are meaningful.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            a_q       <= rdata_a;
            b_q       <= rdata_b;
            alu_out_q <= alu_res;
            carry_q   <= carry_d;
        end
    end

    assign out_a_o   = a_q;
    assign out_b_o   = b_q;
    assign alu_out_o = alu_out_q;
    assign alu_res_o = alu_res;
    assign carry_o   = carry_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath: reset, R-type ADD, SUB borrow, link write,
// R0 immunity, PC/branch arithmetic, shifts/NOT and the read/write collision.
module tb_exec_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr, pc, mdr;
    logic        rega_sel, reg_wrt, opa_sel;
    logic [1:0]  data_sel, opb_sel;
    logic [2:0]  alu_sel;
    logic [15:0] out_a, out_b, alu_out, alu_res;
    logic        carry;

    int checks = 0;
    int errors = 0;

    exec_datapath dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .instr_i    (instr),
        .pc_i       (pc),
        .mdr_i      (mdr),
        .rega_sel_i (rega_sel),
        .reg_wrt_i  (reg_wrt),
        .data_sel_i (data_sel),
        .opa_sel_i  (opa_sel),
        .opb_sel_i  (opb_sel),
        .alu_sel_i  (alu_sel),
        .out_a_o    (out_a),
        .out_b_o    (out_b),
        .alu_out_o  (alu_out),
        .alu_res_o  (alu_res),
        .carry_o    (carry)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write a register through the mdr path; alu_sel is left as AND so carry holds.
    task automatic wr(input logic [3:0] r, input logic [15:0] v);
        instr    = {4'h0, r, 8'h00};
        data_sel = 2'b01;
        mdr      = v;
        reg_wrt  = 1'b1;
        tick();
        reg_wrt  = 1'b0;
    endtask

    // Read a register into the A latch.
    task automatic rd_a(input logic [3:0] r, output logic [15:0] v);
        instr    = {4'h0, 4'h0, r, 4'h0};
        rega_sel = 1'b0;
        tick();
        v = out_a;
    endtask

    logic [15:0] v;

    initial begin
        rst_n    = 1'b0;
        instr    = 16'h0000;
        pc       = 16'h0000;
        mdr      = 16'h0000;
        rega_sel = 1'b0;
        reg_wrt  = 1'b0;
        data_sel = 2'b00;
        opa_sel  = 1'b0;
        opb_sel  = 2'b01;
        alu_sel  = 3'b010;
        #12;
        check("reset_a", out_a, 16'h0000);
        check("reset_b", out_b, 16'h0000);
        check("reset_aluout", alu_out, 16'h0000);
        check("reset_carry", {15'b0, carry}, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Mid-instruction asynchronous reset
        wr(4'd3, 16'h1234);
        instr = 16'h0033;
        alu_sel = 3'b000;
        tick();
        check("pre_rst_a", out_a, 16'h1234);
        tick();
        check("pre_rst_aluout", alu_out, 16'h2468);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a", out_a, 16'h0000);
        check("async_rst_b", out_b, 16'h0000);
        check("async_rst_aluout", alu_out, 16'h0000);
        alu_sel = 3'b010;
        rst_n = 1'b1;
        rd_a(4'd3, v);
        check("async_rst_r3", v, 16'h0000);

        // R-type ADD across s1 -> s2 -> s3
        wr(4'd1, 16'hFFFF);
        wr(4'd2, 16'h0001);
        wr(4'd3, 16'h5555);
        instr = 16'h0312;
        rega_sel = 1'b0;
        opa_sel = 1'b0;
        opb_sel = 2'b01;
        alu_sel = 3'b000;
        data_sel = 2'b00;
        tick();
        check("add_a", out_a, 16'hFFFF);
        check("add_b", out_b, 16'h0001);
        tick();
        check("add_aluout", alu_out, 16'h0000);
        check("add_carry", {15'b0, carry}, 16'h0001);
        alu_sel = 3'b010;
        reg_wrt = 1'b1;
        tick();
        reg_wrt = 1'b0;
        check("and_holds_carry", {15'b0, carry}, 16'h0001);
        rd_a(4'd3, v);
        check("add_r3", v, 16'h0000);

        // SUB with and without borrow
        wr(4'd1, 16'd5);
        wr(4'd2, 16'd7);
        instr = 16'h0312;
        alu_sel = 3'b001;
        tick();
        tick();
        check("sub_borrow_res", alu_out, 16'hFFFE);
        check("sub_borrow_carry", {15'b0, carry}, 16'h0001);
        alu_sel = 3'b010;
        wr(4'd1, 16'd7);
        wr(4'd2, 16'd5);
        instr = 16'h0312;
        alu_sel = 3'b001;
        tick();
        tick();
        check("sub_res", alu_out, 16'h0002);
        check("sub_carry", {15'b0, carry}, 16'h0000);
        alu_sel = 3'b010;

        // Jump-and-link goes to R15, not rd
        wr(4'd4, 16'h7777);
        pc = 16'h0040;
        instr = 16'h0400;
        data_sel = 2'b10;
        reg_wrt = 1'b1;
        tick();
        reg_wrt = 1'b0;
        rd_a(4'd15, v);
        check("jal_r15", v, 16'h0040);
        rd_a(4'd4, v);
        check("jal_r4_kept", v, 16'h7777);

        // R0 ignores writes of a nonzero ALUOut
        opa_sel = 1'b1;
        opb_sel = 2'b00;
        alu_sel = 3'b000;
        tick();
        check("aluout_pc1", alu_out, 16'h0041);
        alu_sel = 3'b010;
        instr = 16'h0000;
        data_sel = 2'b00;
        reg_wrt = 1'b1;
        tick();
        reg_wrt = 1'b0;
        rd_a(4'd0, v);
        check("r0_a", v, 16'h0000);
        check("r0_b", out_b, 16'h0000);

        // PC increment and sign-extended branch offset
        pc = 16'h00FF;
        opa_sel = 1'b1;
        opb_sel = 2'b00;
        alu_sel = 3'b000;
        #1;
        check("pc_inc", alu_res, 16'h0100);
        instr = 16'h00FE;
        opb_sel = 2'b11;
        #1;
        check("branch_off", alu_res, 16'h00FD);

        // NOT, shifts and their carry
        alu_sel = 3'b101;
        #1;
        check("not_x", alu_res, 16'hFF00);
        pc = 16'h8001;
        alu_sel = 3'b110;
        #1;
        check("shl_res", alu_res, 16'h0002);
        tick();
        check("shl_carry", {15'b0, carry}, 16'h0001);
        pc = 16'h0002;
        alu_sel = 3'b111;
        #1;
        check("shr_res", alu_res, 16'h0001);
        tick();
        check("shr_carry", {15'b0, carry}, 16'h0000);
        pc = 16'h00F0;
        instr = 16'h000F;
        alu_sel = 3'b100;
        #1;
        check("xor_res", alu_res, 16'h00FF);
        alu_sel = 3'b011;
        instr = 16'h0081;
        #1;
        check("or_sext", alu_res, 16'hFFF1);
        alu_sel = 3'b010;
        opa_sel = 1'b0;
        opb_sel = 2'b01;

        // Read/write collision returns the old value, new value one edge later
        wr(4'd5, 16'h1111);
        instr = 16'h0550;
        rega_sel = 1'b0;
        data_sel = 2'b01;
        mdr = 16'hABCD;
        reg_wrt = 1'b1;
        tick();
        reg_wrt = 1'b0;
        check("collide_old", out_a, 16'h1111);
        tick();
        check("collide_new", out_a, 16'hABCD);

        // rega_sel picks rd
        instr = 16'h0500;
        rega_sel = 1'b1;
        tick();
        check("rega_rd", out_a, 16'hABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_datapath.md
Name: exec_datapath

Overview:
- Execution datapath of the 16-bit multicycle core; consumes every datapath-steering output of the control FSM.
- Contains a 16x16 register file, the A/B operand latches, the ALU input muxes and the ALU, the ALUOut register, the carry flag, and the register write-back mux.
- Returns outA and carry to the control FSM. Provides alu_out and the B latch to the PC/memory stage.

Parameters:
- DW, 16, data and register width.
- NREG, 16, number of registers. The address width is log2(NREG) = 4.
- LINK_REG, 15, register index written by jump-and-link.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- instr  in  16  IR contents: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt, [7:0] imm8
- pc  in  16  current program counter
- mdr  in  16  memory data register
- rega_sel  in  1  A read address: 0 = rs, 1 = rd
- reg_wrt  in  1  register file write enable
- data_sel  in  2  write-back source: 00 ALUOut, 01 mdr, 10 pc, 11 sext(imm8)
- opa_sel  in  1  ALU A operand: 0 = A latch, 1 = pc
- opb_sel  in  2  ALU B operand: 00 const 1, 01 B latch, 10 const 0, 11 sext(imm8)
- alu_sel  in  3  ALU operation
- outA  out  16  A latch, fed to the control FSM zero test
- outB  out  16  B latch, used as store data
- alu_out  out  16  ALUOut register
- alu_res  out  16  combinational ALU result, used as the next-PC source
- carry  out  1  carry flag register

Behaviour:
- Reset (reset = 0, asynchronous):
  - All registers, A, B, ALUOut and carry go to 0.
  - Writes are blocked while reset is low.
  - Asserting reset mid-instruction discards all in-flight values.
- Register file:
  - Read address RA = rega_sel ? rd : rs. Read address RB = rt.
  - R0 always reads 0. Writes to R0 are ignored.
- Write port: active on a rising edge when reg_wrt = 1.
  - Write address WA = (data_sel == 10) ? LINK_REG : rd.
  - Write data is selected by data_sel.
  - sext(imm8) = {{8{imm8[7]}}, imm8}.
- Latches (every rising edge):
  - A <= RF[RA]; B <= RF[RB]; ALUOut <= alu_res.
  - Capture is unconditional. The control FSM sequencing makes the held values valid.
- Read/write collision: a same-edge write and read of the same register returns the OLD value into A/B. The new value is visible one edge later. There is no bypass.
- ALU operations (alu_sel), with X and Y the selected operands:
  - 000 ADD: result X+Y; carry = bit 16 of the 17-bit sum.
  - 001 SUB: result X-Y; carry = 1 iff X < Y unsigned (borrow).
  - 010 AND, 011 OR, 100 XOR: carry unchanged.
  - 101 NOT X: carry unchanged.
  - 110 SHL by 1: carry = X[15].
  - 111 SHR logical by 1: carry = X[0].
- Arithmetic wraps modulo 2^16. There is no overflow flag.
- Carry update: carry is registered on every edge using the rule above. When the rule says "unchanged", the register holds its value.
- alu_res is purely combinational. alu_out lags alu_res by one cycle.
- Latency from instruction register to result:
  - The operand read appears in A/B 1 edge after instr/rega_sel are stable.
  - The ALU result reaches ALUOut 1 edge later.
  - Write-back happens on the next edge with reg_wrt = 1.
  - An R-type instruction therefore completes in the s1 -> s2 -> s3 sequence.
- No X propagation: all mux select codes are fully decoded.

Test Plan:
- Reset: load R3 = 16'h1234, then pulse reset low between clock edges -> outA, outB, alu_out and carry read 0 immediately; R3 reads 0 afterwards.
- R-type ADD: R1 = 16'hFFFF, R2 = 16'h0001, instr = 16'h0312 (rd = 3, rs = 1, rt = 2), opa_sel = 0, opb_sel = 01, alu_sel = 000, reg_wrt in the third cycle -> alu_out = 16'h0000, carry = 1, R3 = 16'h0000.
- SUB borrow: R1 = 5, R2 = 7, alu_sel = 001 -> alu_out = 16'hFFFE, carry = 1. Then with R1 = 7, R2 = 5 -> alu_out = 16'h0002, carry = 0.
- Jump-and-link write: pc = 16'h0040, data_sel = 10, reg_wrt = 1, rd = 4 -> R15 = 16'h0040, R4 unchanged. Then rd = 0 with data_sel = 00 and reg_wrt = 1 -> R0 still reads 0.
- PC increment and branch offset:
  - opa_sel = 1, opb_sel = 00, pc = 16'h00FF -> alu_res = 16'h0100.
  - imm8 = 8'hFE, opb_sel = 11 -> alu_res = 16'h00FD.
- Collision: write R5 = 16'hABCD while rs = 5 on the same edge -> outA keeps the old R5; one edge later outA = 16'hABCD.
